// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS32 ALU result stage: select codes, stage
// state encoding and the registered result entry.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SEL_W = 4;

    typedef enum logic [3:0] {
        SEL_SLL = 4'd0,
        SEL_SRL = 4'd1,
        SEL_SRA = 4'd2,
        SEL_ADD = 4'd3,
        SEL_SUB = 4'd4,
        SEL_AND = 4'd5,
        SEL_OR  = 4'd6,
        SEL_SLT = 4'd7
    } alu_sel_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 zero;
        logic                 err;
        logic [ALU_SEL_W-1:0] sel;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_mux.sv
// Combinational selection of one function-unit result, with zero and
// illegal-select flags; an out-of-range select yields a zero result.
module alu_result_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = 4
) (
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] results,
    output logic [WIDTH-1:0]         result,
    output logic                     zero,
    output logic                     err
);

    // Scan all sources; err stays set unless some source index matches.
    always_comb begin
        result = {WIDTH{1'b0}};
        err    = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                result = results[k*WIDTH +: WIDTH];
                err    = 1'b0;
            end else begin
                err    = err;
            end
        end
        zero = (result == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: result mux feeding a 2-entry skid buffer with
// a valid/ready handshake and a delivered-result counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = ALU_SEL_W,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [NUM_SRC*WIDTH-1:0] in_results,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_zero,
    output logic                     out_err,
    output logic [SEL_W-1:0]         out_sel,
    output logic [CNT_W-1:0]         out_count
);

    stage_state_e state_r, state_nxt_s;
    alu_entry_t   main_r, skid_r, main_nxt_s, skid_nxt_s, new_s;
    logic         out_valid_r, in_ready_r;
    logic [CNT_W-1:0] count_r;
    logic         in_fire_s, out_fire_s;

    alu_result_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .sel     (in_sel),
        .results (in_results),
        .result  (new_s.result),
        .zero    (new_s.zero),
        .err     (new_s.err)
    );

    assign new_s.sel  = in_sel;
    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Next-state and main/skid load decisions.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        case (state_r)
            EMPTY: begin
                if (in_fire_s) begin
                    state_nxt_s = ONE;
                    main_nxt_s  = new_s;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            ONE: begin
                if (in_fire_s && !out_ready) begin
                    state_nxt_s = FULL;
                    skid_nxt_s  = new_s;
                end else if (in_fire_s) begin
                    main_nxt_s  = new_s;
                end else if (out_ready) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nxt_s = ONE;
                    main_nxt_s  = skid_r;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State, storage and handshake flags; ready/valid derive from next state
    // so neither has a combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            count_r     <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            out_valid_r <= (state_nxt_s != EMPTY);
            in_ready_r  <= (state_nxt_s != FULL);
            if (out_fire_s) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = main_r.result;
    assign out_zero   = main_r.zero;
    assign out_err    = main_r.err;
    assign out_sel    = main_r.sel;
    assign out_count  = count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a vector table of single transfers
// plus hand-written stream, backpressure, reset and counter-wrap sequences.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 8;
    localparam int SEL_W   = 4;
    localparam int CNT_W   = 16;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         in_sel;
    logic [NUM_SRC*WIDTH-1:0] in_results;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_result;
    logic                     out_zero;
    logic                     out_err;
    logic [SEL_W-1:0]         out_sel;
    logic [CNT_W-1:0]         out_count;

    int n_checks;
    int n_fails;

    alu_result_stage #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_results (in_results),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .out_sel    (out_sel),
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [31:0]      fill;
        logic [31:0]      val;
        logic [31:0]      exp_result;
        logic             exp_zero;
        logic             exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_SRC*WIDTH-1:0] build(input logic [SEL_W-1:0] sel,
                                                       input logic [31:0] fill,
                                                       input logic [31:0] val);
        logic [NUM_SRC*WIDTH-1:0] r;
        for (int k = 0; k < NUM_SRC; k++) begin
            r[k*WIDTH +: WIDTH] = (SEL_W'(k) == sel) ? val : fill;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'($urandom);
        in_sel     = SEL_W'($urandom);
        in_results = {8{32'($urandom)}};
        out_ready  = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_count", {16'd0, out_count}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        vecs[0] = '{4'd0,  32'h0000_0000, 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0};
        vecs[1] = '{4'd3,  32'h1234_5678, 32'h0000_ABCD, 32'h0000_ABCD, 1'b0, 1'b0};
        vecs[2] = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{4'd7,  32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
        vecs[4] = '{4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1};
        vecs[5] = '{4'd15, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6] = '{4'd8,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{4'd5,  32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};

        do_reset();
        check("rst_out_result", out_result, 32'd0);

        // Table: one transfer at a time, drained before the next.
        for (int i = 0; i < 8; i++) begin
            in_valid   = 1'b1;
            in_sel     = vecs[i].sel;
            in_results = build(vecs[i].sel, vecs[i].fill, vecs[i].val);
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), out_result, vecs[i].exp_result);
            check($sformatf("vec%0d_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].exp_zero});
            check($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_sel", i), {28'd0, out_sel}, {28'd0, vecs[i].sel});
            step();
            check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
        end
        check("table_count", {16'd0, out_count}, 32'd8);

        // Back-to-back stream of 8 results with out_ready held high.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in_valid   = 1'b1;
            in_sel     = SEL_W'(k);
            in_results = build(SEL_W'(k), 32'hDEAD_0000, 32'(k));
            step();
            check($sformatf("stream%0d_valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream%0d_ready", k), {31'd0, in_ready}, 32'd1);
            check($sformatf("stream%0d_result", k), out_result, 32'(k));
            check($sformatf("stream%0d_zero", k), {31'd0, out_zero}, (k == 0) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        step();
        check("stream_count", {16'd0, out_count}, 32'd8);
        check("stream_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure fills the skid; data held and delivered in order.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 4'd3;
        in_results = build(4'd3, 32'd0, 32'hAAAA_0000);
        step();
        check("bp_first_ready", {31'd0, in_ready}, 32'd1);
        in_sel     = 4'd4;
        in_results = build(4'd4, 32'd0, 32'h0000_BBBB);
        step();
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_a", out_result, 32'hAAAA_0000);
        in_sel     = 4'd5;
        in_results = build(4'd5, 32'd0, 32'hDEAD_BEEF);
        step();
        in_valid = 1'b0;
        check("bp_hold_a2", out_result, 32'hAAAA_0000);
        check("bp_hold_sel", {28'd0, out_sel}, 32'd3);
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_b_valid", {31'd0, out_valid}, 32'd1);
        check("bp_b_result", out_result, 32'h0000_BBBB);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_no_extra", {31'd0, out_valid}, 32'd0);
        check("bp_count", {16'd0, out_count}, 32'd10);

        // Reset while FULL drops everything immediately.
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 4'd1;
        in_results = build(4'd1, 32'd0, 32'h1111_1111);
        step();
        step();
        in_valid = 1'b0;
        check("rf_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rf_async_valid", {31'd0, out_valid}, 32'd0);
        check("rf_async_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        step();
        step();
        check("rf_no_stale", {31'd0, out_valid}, 32'd0);
        check("rf_count", {16'd0, out_count}, 32'd0);

        // Counter wrap after 65536 deliveries.
        do_reset();
        in_valid   = 1'b1;
        in_sel     = 4'd6;
        in_results = build(4'd6, 32'd0, 32'h0000_0006);
        repeat (65535) step();
        in_valid = 1'b0;
        step();
        check("wrap_max", {16'd0, out_count}, 32'h0000_FFFF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("wrap_zero", {16'd0, out_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
